// File: rtl/ss_seq.sv
// Save-state sequencer: walks mapper slots 0..LAST_ADDR, copying slot bytes to a
// buffer memory (save) or writing buffered bytes back over the save-state bus (restore).
module ss_seq #(
   parameter int LAST_ADDR = 127,
   parameter int RD_SETTLE = 4,
   parameter int WE_HOLD   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mode,
   input  logic [7:0] map_idx,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       ss_act,
   output logic       ss_we,
   output logic [7:0] ss_addr,
   output logic [7:0] ss_wdat,
   input  logic [7:0] ss_rdat,
   output logic       mem_req,
   output logic       mem_we,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdat,
   input  logic [7:0] mem_rdat,
   input  logic       mem_ack
);

   typedef enum logic [2:0] {
      IDLE,
      SV_SET,
      SV_WR,
      RS_CHK,
      RS_RD,
      RS_WE,
      RS_GAP,
      FIN
   } state_t;

   localparam logic [7:0]  LAST       = 8'(LAST_ADDR);
   localparam logic [15:0] SETTLE_END = 16'(RD_SETTLE);
   localparam logic [15:0] HOLD_END   = 16'(WE_HOLD - 1);

   state_t      state;
   logic [7:0]  addr;
   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         addr     <= 8'd0;
         cnt      <= 16'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         ss_act   <= 1'b0;
         ss_we    <= 1'b0;
         ss_addr  <= 8'd0;
         ss_wdat  <= 8'd0;
         mem_req  <= 1'b0;
         mem_we   <= 1'b0;
         mem_addr <= 8'd0;
         mem_wdat <= 8'd0;
      end else begin
         done <= 1'b0;
         case (state)
            // FIN already has busy low, so a start arriving there is accepted too.
            IDLE, FIN: begin
               state <= IDLE;
               if (start) begin
                  err    <= 1'b0;
                  busy   <= 1'b1;
                  ss_act <= 1'b1;
                  cnt    <= 16'd0;
                  addr   <= 8'd0;
                  if (mode) begin
                     state <= RS_CHK;
                  end else begin
                     state   <= SV_SET;
                     ss_addr <= 8'd0;
                  end
               end
            end

            // ss_addr has been stable for RD_SETTLE full cycles when ss_rdat is sampled.
            SV_SET: begin
               if (cnt == SETTLE_END) begin
                  mem_wdat <= ss_rdat;
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b1;
                  mem_addr <= addr;
                  state    <= SV_WR;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            SV_WR: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (addr == LAST) begin
                     state  <= FIN;
                     busy   <= 1'b0;
                     ss_act <= 1'b0;
                     done   <= 1'b1;
                  end else begin
                     addr    <= addr + 8'd1;
                     ss_addr <= addr + 8'd1;
                     cnt     <= 16'd0;
                     state   <= SV_SET;
                  end
               end
            end

            RS_CHK: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= LAST;
               end else if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (mem_rdat != map_idx) begin
                     err    <= 1'b1;
                     state  <= FIN;
                     busy   <= 1'b0;
                     ss_act <= 1'b0;
                     done   <= 1'b1;
                  end else begin
                     addr  <= 8'd0;
                     state <= RS_RD;
                  end
               end
            end

            // ss_addr moves here, while ss_we is low, well ahead of the write strobe.
            RS_RD: begin
               if (!mem_req) begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= addr;
                  ss_addr  <= addr;
               end else if (mem_ack) begin
                  mem_req <= 1'b0;
                  ss_wdat <= mem_rdat;
                  ss_we   <= 1'b1;
                  cnt     <= 16'd0;
                  state   <= RS_WE;
               end
            end

            RS_WE: begin
               if (cnt == HOLD_END) begin
                  ss_we <= 1'b0;
                  state <= RS_GAP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            RS_GAP: begin
               if (addr == LAST) begin
                  state  <= FIN;
                  busy   <= 1'b0;
                  ss_act <= 1'b0;
                  done   <= 1'b1;
               end else begin
                  addr  <= addr + 8'd1;
                  state <= RS_RD;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ss_seq.sv
// Directed bench for ss_seq: default-size instance (a) and a 16-slot, fast-timing instance (b).
module tb_ss_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start_a = 1'b0, start_b = 1'b0, mode = 1'b0;
   logic [7:0] map_idx_a = 8'd0, map_idx_b = 8'd0;

   logic       busy_a, done_a, err_a, act_a, we_a, mreq_a, mwe_a;
   logic [7:0] addr_a, wdat_a, rdat_a, maddr_a, mwdat_a;
   logic [7:0] mrdat_a = 8'd0;
   logic       ack_a = 1'b0;

   logic       busy_b, done_b, err_b, act_b, we_b, mreq_b, mwe_b;
   logic [7:0] addr_b, wdat_b, rdat_b, maddr_b, mwdat_b;
   logic [7:0] mrdat_b = 8'd0;
   logic       ack_b = 1'b0;

   int checks = 0;
   int errors = 0;

   logic [7:0] buf_a [256];
   logic [7:0] buf_b [256];
   logic [7:0] slots_a [256];
   logic [7:0] slots_b [256];
   logic [1:0] fill_a = 2'd0;
   logic       fill_b = 1'b0;
   logic [7:0] fill_last = 8'd0;
   logic       stall = 1'b0;
   logic       clr = 1'b0;
   int wc_a = 0, wc_b = 0;

   int pulses_a = 0, badw_a = 0, run_a = 0, dones_a = 0, busyc_a = 0, viol_a = 0;
   int pulses_b = 0, badw_b = 0, run_b = 0, dones_b = 0, busyc_b = 0, viol_b = 0, maxaddr_b = 0;
   logic [7:0] paddr_a = 8'd0, pmaddr_a = 8'd0, paddr_b = 8'd0, pmaddr_b = 8'd0;
   logic preq_a = 1'b0, pack_a = 1'b0, pmwe_a = 1'b0;
   logic preq_b = 1'b0, pack_b = 1'b0, pmwe_b = 1'b0;

   ss_seq u_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode), .map_idx(map_idx_a),
      .busy(busy_a), .done(done_a), .err(err_a), .ss_act(act_a), .ss_we(we_a),
      .ss_addr(addr_a), .ss_wdat(wdat_a), .ss_rdat(rdat_a),
      .mem_req(mreq_a), .mem_we(mwe_a), .mem_addr(maddr_a), .mem_wdat(mwdat_a),
      .mem_rdat(mrdat_a), .mem_ack(ack_a)
   );

   ss_seq #(.LAST_ADDR(15), .RD_SETTLE(1), .WE_HOLD(1)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode), .map_idx(map_idx_b),
      .busy(busy_b), .done(done_b), .err(err_b), .ss_act(act_b), .ss_we(we_b),
      .ss_addr(addr_b), .ss_wdat(wdat_b), .ss_rdat(rdat_b),
      .mem_req(mreq_b), .mem_we(mwe_b), .mem_addr(maddr_b), .mem_wdat(mwdat_b),
      .mem_rdat(mrdat_b), .mem_ack(ack_b)
   );

   // Mapper readback model
   assign rdat_a = addr_a ^ 8'h5A;
   assign rdat_b = addr_b ^ 8'h5A;

   // Buffer memories: ack two cycles after a request is seen (frozen while stall is high).
   always @(posedge clk) begin
      ack_a <= 1'b0;
      if (fill_a != 2'd0) begin
         for (int i = 0; i < 256; i++) buf_a[i] <= (fill_a == 2'd1) ? ~8'(i) : 8'hEE;
         if (fill_a == 2'd1) buf_a[127] <= fill_last;
      end else if (!mreq_a) begin
         wc_a <= 0;
      end else if (!ack_a && !stall) begin
         if (wc_a == 1) begin
            ack_a <= 1'b1;
            wc_a  <= 0;
            if (mwe_a) buf_a[maddr_a] <= mwdat_a;
            mrdat_a <= buf_a[maddr_a];
         end else begin
            wc_a <= wc_a + 1;
         end
      end
   end

   always @(posedge clk) begin
      ack_b <= 1'b0;
      if (fill_b) begin
         for (int i = 0; i < 256; i++) buf_b[i] <= 8'hEE;
      end else if (!mreq_b) begin
         wc_b <= 0;
      end else if (!ack_b) begin
         if (wc_b == 1) begin
            ack_b <= 1'b1;
            wc_b  <= 0;
            if (mwe_b) buf_b[maddr_b] <= mwdat_b;
            mrdat_b <= buf_b[maddr_b];
         end else begin
            wc_b <= wc_b + 1;
         end
      end
   end

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) slots_a[i] <= 8'd0;
      end else if (we_a) begin
         slots_a[addr_a] <= wdat_a;
      end
   end

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 256; i++) slots_b[i] <= 8'd0;
      end else if (we_b) begin
         slots_b[addr_b] <= wdat_b;
      end
   end

   // Bus monitors: strobe widths, done/busy counts and handshake/bus invariant violations.
   always @(posedge clk) begin
      if (clr) begin
         pulses_a <= 0; badw_a <= 0; run_a <= 0; dones_a <= 0; busyc_a <= 0; viol_a <= 0;
      end else begin
         if (we_a) run_a <= run_a + 1;
         else if (run_a != 0) begin
            pulses_a <= pulses_a + 1;
            if (run_a != 16) badw_a <= badw_a + 1;
            run_a <= 0;
         end
         if (done_a) dones_a <= dones_a + 1;
         if (busy_a) busyc_a <= busyc_a + 1;
         if ((we_a && !act_a) || (we_a && addr_a != paddr_a) || (preq_a && !pack_a && !mreq_a) ||
             (preq_a && !pack_a && mreq_a && (maddr_a != pmaddr_a || mwe_a != pmwe_a)))
            viol_a <= viol_a + 1;
      end
      paddr_a <= addr_a; preq_a <= mreq_a; pack_a <= ack_a; pmaddr_a <= maddr_a; pmwe_a <= mwe_a;
   end

   always @(posedge clk) begin
      if (clr) begin
         pulses_b <= 0; badw_b <= 0; run_b <= 0; dones_b <= 0; busyc_b <= 0; viol_b <= 0; maxaddr_b <= 0;
      end else begin
         if (we_b) run_b <= run_b + 1;
         else if (run_b != 0) begin
            pulses_b <= pulses_b + 1;
            if (run_b != 1) badw_b <= badw_b + 1;
            run_b <= 0;
         end
         if (done_b) dones_b <= dones_b + 1;
         if (busy_b) busyc_b <= busyc_b + 1;
         if (act_b && int'(addr_b) > maxaddr_b) maxaddr_b <= int'(addr_b);
         if ((we_b && !act_b) || (we_b && addr_b != paddr_b) || (preq_b && !pack_b && !mreq_b) ||
             (preq_b && !pack_b && mreq_b && (maddr_b != pmaddr_b || mwe_b != pmwe_b)))
            viol_b <= viol_b + 1;
      end
      paddr_b <= addr_b; preq_b <= mreq_b; pack_b <= ack_b; pmaddr_b <= maddr_b; pmwe_b <= mwe_b;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_clr();
      @(negedge clk); clr = 1'b1;
      @(negedge clk); clr = 1'b0;
   endtask

   task automatic do_fill(input logic b, input logic [1:0] k, input logic [7:0] last);
      @(negedge clk);
      fill_last = last;
      if (b) fill_b = 1'b1; else fill_a = k;
      @(negedge clk);
      fill_a = 2'd0; fill_b = 1'b0;
   endtask

   task automatic go(input logic b, input logic m);
      @(negedge clk);
      mode = m;
      if (b) start_b = 1'b1; else start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
   endtask

   task automatic wait_done(input logic b, input int lim, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         if (b ? done_b : done_a) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(3);
      checks++;
      if ({busy_a, done_a, err_a, act_a, we_a, mreq_a, mwe_a} !== 7'd0) begin
         errors++; $display("FAIL reset_ctrl_a got %b exp 0", {busy_a, done_a, err_a, act_a, we_a, mreq_a, mwe_a});
      end
      checks++;
      if ({addr_a, wdat_a, maddr_a, mwdat_a} !== 32'd0) begin
         errors++; $display("FAIL reset_data_a got %h exp 0", {addr_a, wdat_a, maddr_a, mwdat_a});
      end
      checks++;
      if ({busy_b, done_b, err_b, act_b, we_b, mreq_b} !== 6'd0) begin
         errors++; $display("FAIL reset_ctrl_b got %b exp 0", {busy_b, done_b, err_b, act_b, we_b, mreq_b});
      end
      rst = 1'b0;
      cyc(2);
   endtask

   task automatic test_save();
      logic ok;
      do_fill(1'b0, 2'd2, 8'd0);
      do_clr();
      go(1'b0, 1'b0);
      checks++;
      if ({busy_a, act_a} !== 2'b11) begin
         errors++; $display("FAIL save_start busy/act got %b exp 11", {busy_a, act_a});
      end
      wait_done(1'b0, 2000, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL save_timeout got %b exp 1", ok); end
      checks++;
      if ({busy_a, act_a} !== 2'b00) begin
         errors++; $display("FAIL save_fin busy/act got %b exp 00", {busy_a, act_a});
      end
      cyc(3);
      checks++;
      if (dones_a !== 1) begin errors++; $display("FAIL save_dones got %0d exp 1", dones_a); end
      checks++;
      if (pulses_a !== 0) begin errors++; $display("FAIL save_we_pulses got %0d exp 0", pulses_a); end
      checks++;
      if (busyc_a !== 1024) begin errors++; $display("FAIL save_cycles got %0d exp 1024", busyc_a); end
      checks++;
      if (err_a !== 1'b0) begin errors++; $display("FAIL save_err got %b exp 0", err_a); end
      checks++;
      if (viol_a !== 0) begin errors++; $display("FAIL save_invariants got %0d exp 0", viol_a); end
      for (int n = 0; n < 128; n++) begin
         checks++;
         if (buf_a[n] !== (8'(n) ^ 8'h5A)) begin
            errors++; $display("FAIL save_buf[%0d] got %h exp %h", n, buf_a[n], 8'(n) ^ 8'h5A);
         end
      end
      checks++;
      if (buf_a[128] !== 8'hEE) begin errors++; $display("FAIL save_buf[128] got %h exp ee", buf_a[128]); end
   endtask

   task automatic test_restore();
      logic ok;
      logic [7:0] exp;
      do_fill(1'b0, 2'd1, 8'h41);
      map_idx_a = 8'h41;
      do_clr();
      go(1'b0, 1'b1);
      wait_done(1'b0, 4000, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL restore_timeout got %b exp 1", ok); end
      cyc(3);
      checks++;
      if (dones_a !== 1) begin errors++; $display("FAIL restore_dones got %0d exp 1", dones_a); end
      checks++;
      if (pulses_a !== 128) begin errors++; $display("FAIL restore_we_pulses got %0d exp 128", pulses_a); end
      checks++;
      if (badw_a !== 0) begin errors++; $display("FAIL restore_we_width bad=%0d exp 0", badw_a); end
      checks++;
      if (slots_a[8] !== 8'hF7) begin errors++; $display("FAIL restore_slot8 got %h exp f7", slots_a[8]); end
      checks++;
      if ({err_a, act_a, busy_a} !== 3'b000) begin
         errors++; $display("FAIL restore_end err/act/busy got %b exp 000", {err_a, act_a, busy_a});
      end
      checks++;
      if (viol_a !== 0) begin errors++; $display("FAIL restore_invariants got %0d exp 0", viol_a); end
      for (int n = 0; n < 128; n++) begin
         exp = (n == 127) ? 8'h41 : ~8'(n);
         checks++;
         if (slots_a[n] !== exp) begin
            errors++; $display("FAIL restore_slot[%0d] got %h exp %h", n, slots_a[n], exp);
         end
      end
   endtask

   task automatic test_mismatch();
      logic ok;
      do_fill(1'b0, 2'd1, 8'h40);
      map_idx_a = 8'h41;
      do_clr();
      go(1'b0, 1'b1);
      wait_done(1'b0, 100, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL mismatch_timeout got %b exp 1", ok); end
      checks++;
      if ({err_a, act_a} !== 2'b10) begin
         errors++; $display("FAIL mismatch_fin err/act got %b exp 10", {err_a, act_a});
      end
      cyc(5);
      checks++;
      if (dones_a !== 1) begin errors++; $display("FAIL mismatch_dones got %0d exp 1", dones_a); end
      checks++;
      if (pulses_a !== 0) begin errors++; $display("FAIL mismatch_we_pulses got %0d exp 0", pulses_a); end
      checks++;
      if ({err_a, busy_a} !== 2'b10) begin
         errors++; $display("FAIL mismatch_sticky err/busy got %b exp 10", {err_a, busy_a});
      end
   endtask

   task automatic test_start_while_busy();
      logic ok;
      logic seen;
      stall = 1'b1;
      do_fill(1'b0, 2'd2, 8'd0);
      do_clr();
      go(1'b0, 1'b0);
      checks++;
      if ({err_a, busy_a} !== 2'b01) begin
         errors++; $display("FAIL busy_start err/busy got %b exp 01", {err_a, busy_a});
      end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (mreq_a) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b1) begin errors++; $display("FAIL busy_req_timeout got %b exp 1", seen); end
      go(1'b0, 1'b1);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks++;
         if ({mreq_a, mwe_a, maddr_a} !== {2'b11, 8'h00}) begin
            errors++; $display("FAIL busy_stall cyc %0d req/we/addr got %b%b/%h exp 11/00", i, mreq_a, mwe_a, maddr_a);
         end
      end
      stall = 1'b0;
      wait_done(1'b0, 2000, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL busy_timeout got %b exp 1", ok); end
      cyc(3);
      checks++;
      if (dones_a !== 1) begin errors++; $display("FAIL busy_dones got %0d exp 1", dones_a); end
      checks++;
      if (pulses_a !== 0) begin errors++; $display("FAIL busy_we_pulses got %0d exp 0", pulses_a); end
      checks++;
      if (viol_a !== 0) begin errors++; $display("FAIL busy_invariants got %0d exp 0", viol_a); end
      checks++;
      if ({buf_a[0], buf_a[64], buf_a[127]} !== 24'h5A1A25) begin
         errors++; $display("FAIL busy_buf got %h exp 5a1a25", {buf_a[0], buf_a[64], buf_a[127]});
      end
   endtask

   task automatic test_reset_mid();
      logic ok;
      logic seen;
      do_fill(1'b0, 2'd1, 8'h41);
      map_idx_a = 8'h41;
      do_clr();
      go(1'b0, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (we_a && addr_a == 8'd20) begin seen = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (seen !== 1'b1) begin errors++; $display("FAIL midrst_reach got %b exp 1", seen); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({we_a, act_a, mreq_a, busy_a, done_a} !== 5'd0) begin
         errors++; $display("FAIL midrst_outputs got %b exp 00000", {we_a, act_a, mreq_a, busy_a, done_a});
      end
      rst = 1'b0;
      cyc(5);
      checks++;
      if (dones_a !== 0) begin errors++; $display("FAIL midrst_dones got %0d exp 0", dones_a); end
      checks++;
      if (slots_a[21] !== 8'h00) begin errors++; $display("FAIL midrst_slot21 got %h exp 00", slots_a[21]); end
      do_fill(1'b0, 2'd2, 8'd0);
      do_clr();
      go(1'b0, 1'b0);
      wait_done(1'b0, 2000, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL midrst_save_timeout got %b exp 1", ok); end
      cyc(3);
      checks++;
      if (busyc_a !== 1024) begin errors++; $display("FAIL midrst_save_cycles got %0d exp 1024", busyc_a); end
      checks++;
      if ({buf_a[0], buf_a[20], buf_a[127]} !== 24'h5A4E25) begin
         errors++; $display("FAIL midrst_save_buf got %h exp 5a4e25", {buf_a[0], buf_a[20], buf_a[127]});
      end
   endtask

   task automatic test_small();
      logic ok;
      do_fill(1'b1, 2'd2, 8'd0);
      do_clr();
      go(1'b1, 1'b0);
      wait_done(1'b1, 500, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL small_save_timeout got %b exp 1", ok); end
      cyc(3);
      checks++;
      if (busyc_b !== 80) begin errors++; $display("FAIL small_save_cycles got %0d exp 80", busyc_b); end
      checks++;
      if (dones_b !== 1) begin errors++; $display("FAIL small_save_dones got %0d exp 1", dones_b); end
      for (int n = 0; n < 16; n++) begin
         checks++;
         if (buf_b[n] !== (8'(n) ^ 8'h5A)) begin
            errors++; $display("FAIL small_buf[%0d] got %h exp %h", n, buf_b[n], 8'(n) ^ 8'h5A);
         end
      end
      checks++;
      if (buf_b[16] !== 8'hEE) begin errors++; $display("FAIL small_buf[16] got %h exp ee", buf_b[16]); end
      map_idx_b = 8'h55;
      do_clr();
      go(1'b1, 1'b1);
      wait_done(1'b1, 500, ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL small_restore_timeout got %b exp 1", ok); end
      cyc(3);
      checks++;
      if (pulses_b !== 16) begin errors++; $display("FAIL small_we_pulses got %0d exp 16", pulses_b); end
      checks++;
      if (badw_b !== 0) begin errors++; $display("FAIL small_we_width bad=%0d exp 0", badw_b); end
      checks++;
      if (maxaddr_b !== 15) begin errors++; $display("FAIL small_max_addr got %0d exp 15", maxaddr_b); end
      checks++;
      if ({err_b, viol_b != 0} !== 2'b00) begin
         errors++; $display("FAIL small_err/invariants got %b/%0d exp 0/0", err_b, viol_b);
      end
      for (int n = 0; n < 16; n++) begin
         checks++;
         if (slots_b[n] !== (8'(n) ^ 8'h5A)) begin
            errors++; $display("FAIL small_slot[%0d] got %h exp %h", n, slots_b[n], 8'(n) ^ 8'h5A);
         end
      end
      checks++;
      if (slots_b[16] !== 8'h00) begin errors++; $display("FAIL small_slot[16] got %h exp 00", slots_b[16]); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_save();
      test_restore();
      test_mismatch();
      test_start_while_busy();
      test_reset_mid();
      test_small();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
